// File: rtl/mem_write_buffer.sv
// mem_write_buffer
// Posted-write buffer between the processor memory stage and a slow data
// memory / MMIO port. Writes are captured into an in-order circular FIFO and
// drained one at a time over a req/ack handshake. A per-entry watchdog drops
// a head entry whose target never acknowledges, so the buffer cannot wedge.
//
// Ports:
//   clk, rst            rising-edge clock, synchronous active-high reset
//   mem_write           write strobe, one write captured per high cycle
//   data_adr            write address (sampled with mem_write)
//   write_data          write data (sampled with mem_write)
//   ext_req             head entry valid and presented to the external port
//   ext_addr, ext_wdata head entry address / data
//   ext_ack             external port accepted the head entry this cycle
//   count, full, empty  occupancy status
//   overflow            sticky: a write was dropped because the buffer was full
//   timeout_err         sticky: an entry was dropped by the watchdog
//
// Handshake: an entry transfers at a rising edge where ext_req=1 and
// ext_ack=1. While ext_req=1 the address/data stay stable until that entry
// is retired (accepted or dropped by the watchdog). ext_ack with ext_req=0
// has no effect.
module mem_write_buffer #(
  parameter int DATA_W  = 22,
  parameter int ADDR_W  = 22,
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     mem_write,
  input  logic [ADDR_W-1:0]        data_adr,
  input  logic [DATA_W-1:0]        write_data,
  output logic                     ext_req,
  output logic [ADDR_W-1:0]        ext_addr,
  output logic [DATA_W-1:0]        ext_wdata,
  input  logic                     ext_ack,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty,
  output logic                     overflow,
  output logic                     timeout_err
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int WD_W  = $clog2(TIMEOUT) + 1;
  localparam int ENT_W = ADDR_W + DATA_W;

  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
  localparam logic [WD_W-1:0]  WD_LAST  = WD_W'(TIMEOUT - 1);

  typedef enum logic {IDLE, REQ} state_t;

  state_t            state;
  logic [ENT_W-1:0]  mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [WD_W-1:0]   wd_cnt;

  logic              ack_pop;
  logic              wd_drop;
  logic              retire;
  logic              push;
  logic [CNT_W-1:0]  count_next;

  // Head entry drives the external port directly; the slot cannot be
  // overwritten while occupied, so the outputs are stable during REQ.
  assign ext_addr  = mem[rd_ptr][ENT_W-1:DATA_W];
  assign ext_wdata = mem[rd_ptr][DATA_W-1:0];
  assign full      = (count == FULL_CNT);
  assign empty     = (count == '0);

  always_comb begin
    ack_pop    = 1'b0;
    wd_drop    = 1'b0;
    retire     = 1'b0;
    push       = 1'b0;
    count_next = count;
    ack_pop    = (state == REQ) && ext_ack;
    // Ack in the final watchdog cycle wins over the drop.
    wd_drop    = (state == REQ) && !ext_ack && (wd_cnt == WD_LAST);
    retire     = ack_pop || wd_drop;
    // A retirement at the same edge frees the slot, so a full buffer can
    // still accept a write (the tail slot equals the retiring head slot).
    push       = mem_write && (!full || retire);
    if (push && !retire) begin
      count_next = count + CNT_W'(1);
    end else if (!push && retire) begin
      count_next = count - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      ext_req     <= 1'b0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      wd_cnt      <= '0;
      overflow    <= 1'b0;
      timeout_err <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (push) begin
        mem[wr_ptr] <= {data_adr, write_data};
        wr_ptr      <= wr_ptr + PTR_W'(1);
      end
      if (retire) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      count <= count_next;
      if (mem_write && !push) begin
        overflow <= 1'b1;
      end
      if (wd_drop) begin
        timeout_err <= 1'b1;
      end
      // Counter restarts for every new head entry; IDLE holds it at zero so
      // entering REQ always begins a fresh window.
      if (state == REQ && !retire) begin
        wd_cnt <= wd_cnt + WD_W'(1);
      end else begin
        wd_cnt <= '0;
      end
      if (count_next != '0) begin
        state   <= REQ;
        ext_req <= 1'b1;
      end else begin
        state   <= IDLE;
        ext_req <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mem_write_buffer.sv
module tb_mem_write_buffer;

  localparam int DATA_W = 22;
  localparam int ADDR_W = 22;
  localparam int ENT_W  = ADDR_W + DATA_W;

  logic              clk;
  logic              rst;
  logic              mem_write;
  logic [ADDR_W-1:0] data_adr;
  logic [DATA_W-1:0] write_data;
  logic              ext_req;
  logic [ADDR_W-1:0] ext_addr;
  logic [DATA_W-1:0] ext_wdata;
  logic              ext_ack;
  logic [2:0]        count;
  logic              full;
  logic              empty;
  logic              overflow;
  logic              timeout_err;

  int vectors    = 0;
  int miscompares = 0;

  logic [ENT_W-1:0] exp_q[$];

  mem_write_buffer #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(4), .TIMEOUT(16)
  ) dut (
    .clk(clk), .rst(rst), .mem_write(mem_write), .data_adr(data_adr),
    .write_data(write_data), .ext_req(ext_req), .ext_addr(ext_addr),
    .ext_wdata(ext_wdata), .ext_ack(ext_ack), .count(count), .full(full),
    .empty(empty), .overflow(overflow), .timeout_err(timeout_err)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Check helper
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    mem_write = 1'b0;
    step();
    rst = 1'b0;
  endtask

  // Issue one write; when expect_issue is set the entry is expected to be
  // accepted by the external port in order.
  task automatic write1(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d,
                        input bit expect_issue);
    mem_write  = 1'b1;
    data_adr   = a;
    write_data = d;
    if (expect_issue) exp_q.push_back({a, d});
    step();
    mem_write = 1'b0;
  endtask

  // Monitor / scoreboard: every accepted transfer is compared with the
  // oldest expected entry.
  always @(negedge clk) begin
    if (rst === 1'b0 && ext_req === 1'b1 && ext_ack === 1'b1) begin
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_issue: got addr %0h data %0h, expected none at %0t",
                 ext_addr, ext_wdata, $time);
      end else begin
        logic [ENT_W-1:0] e;
        e = exp_q.pop_front();
        if ({ext_addr, ext_wdata} !== e) begin
          miscompares++;
          $display("FAIL issue_order: got addr %0h data %0h, expected addr %0h data %0h at %0t",
                   ext_addr, ext_wdata, e[ENT_W-1:DATA_W], e[DATA_W-1:0], $time);
        end
      end
    end
  end

  initial begin
    int hi;
    rst = 1'b1; mem_write = 1'b0; ext_ack = 1'b0;
    data_adr = '0; write_data = '0;

    // Reset state
    do_reset();
    chk("rst_req", 64'(ext_req), 64'd0);
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_empty", 64'(empty), 64'd1);
    chk("rst_full", 64'(full), 64'd0);
    chk("rst_ovf", 64'(overflow), 64'd0);
    chk("rst_tmo", 64'(timeout_err), 64'd0);
    chk("rst_addr", 64'(ext_addr), 64'd0);
    chk("rst_wdata", 64'(ext_wdata), 64'd0);

    // 1. Single write with ack tied high
    ext_ack = 1'b1;
    write1(22'h00010, 22'h3AB12, 1'b1);
    chk("t1_req", 64'(ext_req), 64'd1);
    chk("t1_addr", 64'(ext_addr), 64'h00010);
    chk("t1_wdata", 64'(ext_wdata), 64'h3AB12);
    step();
    chk("t1_req_after", 64'(ext_req), 64'd0);
    chk("t1_empty", 64'(empty), 64'd1);
    chk("t1_count", 64'(count), 64'd0);

    // 2. Overflow: five writes into a 4-deep buffer with ack low
    ext_ack = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      write1(22'(i), 22'(i * 'h11), i <= 4);
    end
    chk("t2_count", 64'(count), 64'd4);
    chk("t2_full", 64'(full), 64'd1);
    chk("t2_ovf", 64'(overflow), 64'd1);
    ext_ack = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      chk("t2_drain_req", 64'(ext_req), 64'd1);
      step();
    end
    ext_ack = 1'b0;
    chk("t2_empty", 64'(empty), 64'd1);
    chk("t2_req_low", 64'(ext_req), 64'd0);

    // 3. Push and pop at the same edge while full
    do_reset();
    for (int i = 1; i <= 4; i++) begin
      write1(22'(8'h20 + i), 22'(8'hA0 + i), 1'b1);
    end
    chk("t3_full_before", 64'(full), 64'd1);
    ext_ack = 1'b1;
    write1(22'h00009, 22'h00099, 1'b1);
    chk("t3_count", 64'(count), 64'd4);
    chk("t3_full", 64'(full), 64'd1);
    chk("t3_ovf", 64'(overflow), 64'd0);
    for (int i = 0; i < 4; i++) step();
    ext_ack = 1'b0;
    chk("t3_empty", 64'(empty), 64'd1);

    // 4a. Watchdog drop after exactly 16 request cycles
    do_reset();
    write1(22'h00030, 22'h12345, 1'b0);
    hi = 0;
    while (ext_req === 1'b1 && hi < 40) begin
      hi++;
      step();
    end
    chk("t4_req_cycles", 64'(hi), 64'd16);
    chk("t4_tmo", 64'(timeout_err), 64'd1);
    chk("t4_empty", 64'(empty), 64'd1);

    // 4b. Ack in the last watchdog cycle wins
    do_reset();
    write1(22'h00031, 22'h2BCDE, 1'b1);
    for (int i = 0; i < 15; i++) step();
    chk("t4b_req16", 64'(ext_req), 64'd1);
    ext_ack = 1'b1;
    step();
    ext_ack = 1'b0;
    chk("t4b_tmo", 64'(timeout_err), 64'd0);
    chk("t4b_empty", 64'(empty), 64'd1);

    // 5. Reset during an outstanding request
    do_reset();
    write1(22'h00051, 22'h00001, 1'b0);
    write1(22'h00052, 22'h00002, 1'b0);
    write1(22'h00053, 22'h00003, 1'b0);
    chk("t5_count_before", 64'(count), 64'd3);
    chk("t5_req_before", 64'(ext_req), 64'd1);
    rst = 1'b1; ext_ack = 1'b1;
    step();
    rst = 1'b0; ext_ack = 1'b0;
    chk("t5_req", 64'(ext_req), 64'd0);
    chk("t5_count", 64'(count), 64'd0);
    chk("t5_ovf", 64'(overflow), 64'd0);
    chk("t5_tmo", 64'(timeout_err), 64'd0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("t5_no_reissue", 64'(ext_req), 64'd0);
    end

    // 6. Spurious acks on an empty buffer, then a normal write
    ext_ack = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("t6_count", 64'(count), 64'd0);
    end
    write1(22'h00040, 22'h3FFFF, 1'b1);
    chk("t6_req", 64'(ext_req), 64'd1);
    chk("t6_addr", 64'(ext_addr), 64'h00040);
    step();
    ext_ack = 1'b0;
    chk("t6_empty", 64'(empty), 64'd1);

    step();
    chk("queue_drained", 64'(exp_q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mem_write_buffer.md
Name: mem_write_buffer

Overview:
- Posted-write buffer between the pipelined processor's memory-stage outputs (mem_write, data_adr, write_data) and an external data-memory/MMIO port that may take several cycles per write.
- The processor pipeline never stalls for memory, so writes are captured into an in-order FIFO and drained over a req/ack handshake.
- A per-write watchdog keeps a dead target from wedging the buffer.
- Overflow and timeout conditions are reported through sticky status flags.

Parameters:
- DATA_W, 22, width of write data.
- ADDR_W, 22, width of write address.
- DEPTH, 4, number of FIFO entries; power of two, minimum 2.
- TIMEOUT, 16, cycles ext_req may stay high for one entry without ext_ack before that entry is dropped; minimum 1.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- mem_write  in  1  processor write strobe; one write per cycle it is high.
- data_adr  in  ADDR_W  write address, sampled when mem_write=1.
- write_data  in  DATA_W  write data, sampled when mem_write=1.
- ext_req  out  1  head entry valid and presented to the external port.
- ext_addr  out  ADDR_W  head entry address.
- ext_wdata  out  DATA_W  head entry data.
- ext_ack  in  1  external port accepted the head entry this cycle.
- count  out  $clog2(DEPTH)+1  number of occupied entries, 0..DEPTH.
- full  out  1  count==DEPTH.
- empty  out  1  count==0.
- overflow  out  1  sticky: a write was dropped because the buffer was full.
- timeout_err  out  1  sticky: an entry was dropped by the watchdog.

Behaviour:
Interface:
- One clock, clk. Reset rst is synchronous and active-high.

Reset:
- While rst=1 at a clock edge: FIFO emptied, read/write pointers 0, count=0, empty=1, full=0.
- ext_req=0, overflow=0, timeout_err=0, watchdog counter 0, FSM in IDLE.
- ext_addr and ext_wdata are 0 after reset.
- mem_write and ext_ack are ignored in reset cycles.
- Reset during an outstanding request discards all entries, including the head. ext_req is low the cycle after.

Storage:
- Circular FIFO with wrapping pointers. Entry = {addr, data}.
- Outputs are driven from the head entry. ext_req = (state==REQ).

Push:
- mem_write=1 and (not full, or a pop occurs this same edge) -> entry written at tail, tail increments (wraps DEPTH-1 -> 0).
- mem_write=1, full, no pop this edge -> write dropped, overflow set to 1, count unchanged.

Pop:
- At an edge with ext_req=1 and ext_ack=1 -> head retired, head pointer increments.
- ext_ack while ext_req=0 is ignored.

Simultaneous push and pop:
- count unchanged. Both pointers advance.
- Allowed when full: no overflow.
- A push into an empty buffer is not visible as the head until the next cycle.

Latency:
- mem_write at edge N into an empty buffer -> ext_req=1, with that entry's addr/data, during cycle N+1.
- After an ack with further entries queued, the next entry is presented the following cycle. ext_req stays high continuously.

FSM:
- IDLE: ext_req=0. Go to REQ when count becomes nonzero (after a push).
- REQ: ext_req=1, and ext_addr/ext_wdata are held stable until retirement.
  - On ack or timeout drop: stay in REQ if entries remain, otherwise go to IDLE.

Watchdog:
- Counter cleared on entering REQ and on each retirement.
- Increments each REQ cycle without ack.
- If the counter equals TIMEOUT-1 and ext_ack=0 at an edge: head dropped (popped), timeout_err set to 1, counter cleared.
- ext_ack in that same cycle takes priority: normal pop, no error.

Status:
- overflow and timeout_err clear only on rst.
- count, full and empty reflect the registered state after each edge.

Ordering:
- Entries are issued strictly in push order. No merging and no reordering.

Test Plan:
1. Single write: rst, then mem_write=1 with adr=0x00010, data=0x3AB12 for one cycle, ext_ack tied 1 -> next cycle ext_req=1, ext_addr=0x00010, ext_wdata=0x3AB12. Cycle after that ext_req=0, empty=1, count=0.
2. Overflow: ext_ack=0, five consecutive writes (adr 1..5, data 0x11..0x55), DEPTH=4 -> count=4, full=1, overflow=1 after the 5th. Raising ext_ack then drains adr 1,2,3,4 in order, one per cycle. adr 5 is never issued.
3. Full push/pop: fill to 4, then same cycle mem_write (adr 9) and ext_ack=1 -> count stays 4, overflow=0. adr 9 emerges after the existing three remaining entries.
4. Timeout: TIMEOUT=16, one write, ext_ack=0 -> ext_req high exactly 16 cycles, then the entry is dropped, timeout_err=1, empty=1. Repeat with ack in the 16th cycle -> no error.
5. Reset mid-operation: three entries queued, ext_req=1, assert rst one cycle with ext_ack=1 -> next cycle ext_req=0, count=0, flags 0. No entry is reissued.
6. Spurious ack: empty buffer, ext_ack=1 for 5 cycles -> count stays 0, pointers unchanged. A subsequent write is issued normally.
